// File: rtl/rom_lookup_arbiter.sv
// Two-requester round-robin lookup front end for a shared 32x8 ROM with
// two-edge read latency, plus a full-table mod-256 checksum scan.
module rom_lookup_arbiter (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [4:0] req0_addr,
   output logic       req0_ready,
   output logic       rsp0_valid,
   output logic [7:0] rsp0_data,
   input  logic       req1_valid,
   input  logic [4:0] req1_addr,
   output logic       req1_ready,
   output logic       rsp1_valid,
   output logic [7:0] rsp1_data,
   input  logic       scan_start,
   output logic       scan_busy,
   output logic       scan_done,
   output logic [7:0] scan_sum,
   output logic [4:0] rom_addr,
   input  logic [7:0] rom_data
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_REQ0 = 2'd1;
   localparam logic [1:0] TAG_REQ1 = 2'd2;
   localparam logic [1:0] TAG_SCAN = 2'd3;

   state_t           r_state;
   logic [2:0][1:0]  r_tag;
   logic [4:0]       r_scan_idx;
   logic             r_last_grant;

   logic             w_open;
   logic             w_start;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_scan_last;
   logic [1:0]       w_tag_in;

   assign w_open   = (r_state == IDLE) && !scan_start;
   assign w_start  = (r_state == IDLE) && scan_start;
   // r_last_grant==1 means requester 1 went last, so requester 0 wins a tie.
   assign w_grant0 = w_open && req0_valid && (!req1_valid || r_last_grant);
   assign w_grant1 = w_open && req1_valid && (!req0_valid || !r_last_grant);

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   // Last scan byte lands when the oldest tag is SCAN and nothing scan-tagged follows it.
   assign w_scan_last = (r_state == DRAIN) && (r_tag[2] == TAG_SCAN) && (r_tag[1] != TAG_SCAN);

   always_comb begin
      w_tag_in = TAG_NONE;
      if (w_start || r_state == SCAN)
         w_tag_in = TAG_SCAN;
      else if (w_grant0)
         w_tag_in = TAG_REQ0;
      else if (w_grant1)
         w_tag_in = TAG_REQ1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_tag        <= '0;
         r_scan_idx   <= '0;
         r_last_grant <= 1'b1;
         rom_addr     <= '0;
         rsp0_valid   <= 1'b0;
         rsp0_data    <= '0;
         rsp1_valid   <= 1'b0;
         rsp1_data    <= '0;
         scan_busy    <= 1'b0;
         scan_done    <= 1'b0;
         scan_sum     <= '0;
      end else begin
         r_tag     <= {r_tag[1], r_tag[0], w_tag_in};
         scan_done <= 1'b0;

         rsp0_valid <= (r_tag[2] == TAG_REQ0);
         rsp1_valid <= (r_tag[2] == TAG_REQ1);
         if (r_tag[2] == TAG_REQ0)
            rsp0_data <= rom_data;
         if (r_tag[2] == TAG_REQ1)
            rsp1_data <= rom_data;
         if (r_tag[2] == TAG_SCAN)
            scan_sum <= scan_sum + rom_data;

         if (w_grant0) begin
            rom_addr     <= req0_addr;
            r_last_grant <= 1'b0;
         end else if (w_grant1) begin
            rom_addr     <= req1_addr;
            r_last_grant <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (scan_start) begin
                  r_state    <= SCAN;
                  scan_busy  <= 1'b1;
                  scan_sum   <= '0;
                  rom_addr   <= '0;
                  r_scan_idx <= 5'd1;
               end
            end
            SCAN: begin
               rom_addr   <= r_scan_idx;
               r_scan_idx <= r_scan_idx + 5'd1;
               if (r_scan_idx == 5'd31)
                  r_state <= DRAIN;
            end
            DRAIN: begin
               if (w_scan_last) begin
                  r_state   <= IDLE;
                  scan_busy <= 1'b0;
                  scan_done <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// Scoreboard bench for rom_lookup_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares data and arrival edge.
module tb_rom_lookup_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0;
   logic [4:0] req0_addr = '0;
   logic       req0_ready;
   logic       rsp0_valid;
   logic [7:0] rsp0_data;
   logic       req1_valid = 1'b0;
   logic [4:0] req1_addr = '0;
   logic       req1_ready;
   logic       rsp1_valid;
   logic [7:0] rsp1_data;
   logic       scan_start = 1'b0;
   logic       scan_busy;
   logic       scan_done;
   logic [7:0] scan_sum;
   logic [4:0] rom_addr;
   logic [7:0] rom_data = '0;
   logic [4:0] rom_a_q = '0;

   int checks = 0;
   int errors = 0;
   int cycle_cnt = 0;
   int s0;

   typedef struct packed {
      logic [7:0] d;
      int         cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t qs[$];
   logic [7:0] hold0 = '0;
   logic [7:0] hold1 = '0;

   rom_lookup_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_ready (req0_ready),
      .rsp0_valid (rsp0_valid),
      .rsp0_data  (rsp0_data),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_ready (req1_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_data  (rsp1_data),
      .scan_start (scan_start),
      .scan_busy  (scan_busy),
      .scan_done  (scan_done),
      .scan_sum   (scan_sum),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cycle_cnt <= cycle_cnt + 1;
      rom_a_q   <= rom_addr;
      rom_data  <= {3'b000, rom_a_q} + 8'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cycle_cnt, act, exp);
      end
   endtask

   always @(posedge reset) begin
      hold0 = '0;
      hold1 = '0;
   end

   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (rsp0_valid) begin
            if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
            else begin
               e = q0.pop_front();
               chk("rsp0_data", rsp0_data, e.d);
               chk("rsp0_edge", cycle_cnt, e.cyc);
               hold0 = e.d;
            end
         end else begin
            chk("rsp0_hold", rsp0_data, hold0);
            if (q0.size() > 0 && q0[0].cyc < cycle_cnt) begin
               e = q0.pop_front();
               chk("rsp0_missing", 0, 1);
            end
         end
         if (rsp1_valid) begin
            if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
            else begin
               e = q1.pop_front();
               chk("rsp1_data", rsp1_data, e.d);
               chk("rsp1_edge", cycle_cnt, e.cyc);
               hold1 = e.d;
            end
         end else begin
            chk("rsp1_hold", rsp1_data, hold1);
            if (q1.size() > 0 && q1[0].cyc < cycle_cnt) begin
               e = q1.pop_front();
               chk("rsp1_missing", 0, 1);
            end
         end
         if (scan_done) begin
            if (qs.size() == 0) chk("scan_done_unexpected", 1, 0);
            else begin
               e = qs.pop_front();
               chk("scan_sum", scan_sum, e.d);
               chk("scan_done_edge", cycle_cnt, e.cyc);
               chk("scan_busy_at_done", scan_busy, 0);
            end
         end else if (qs.size() > 0 && qs[0].cyc < cycle_cnt) begin
            e = qs.pop_front();
            chk("scan_done_missing", 0, 1);
         end
      end
   end

   // One stimulus cycle: drive at negedge, check readies, queue expected responses.
   task automatic cyc(input bit v0, input logic [4:0] a0, input logic [7:0] e0,
                      input bit v1, input logic [4:0] a1, input logic [7:0] e1,
                      input bit st, input bit x0, input bit x1);
      @(negedge clock);
      req0_valid = v0;
      req0_addr  = a0;
      req1_valid = v1;
      req1_addr  = a1;
      scan_start = st;
      #1;
      chk("req0_ready", req0_ready, x0);
      chk("req1_ready", req1_ready, x1);
      if (x0) q0.push_back('{d: e0, cyc: cycle_cnt + 4});
      if (x1) q1.push_back('{d: e1, cyc: cycle_cnt + 4});
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_zero_outputs();
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp0_data", rsp0_data, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp1_data", rsp1_data, 0);
      chk("rst_scan_busy", scan_busy, 0);
      chk("rst_scan_done", scan_done, 0);
      chk("rst_scan_sum", scan_sum, 0);
   endtask

   // Runs 40 cycles from S0 with requesters pushing; readies must stay low, busy spans S0..S0+33.
   task automatic scan_run(input int start_edge, input int ign_at);
      bit busy_exp;
      repeat (40) begin
         @(negedge clock);
         busy_exp   = (cycle_cnt >= start_edge) && (cycle_cnt < start_edge + 34);
         req0_valid = busy_exp;
         req0_addr  = 5'd3;
         req1_valid = busy_exp;
         req1_addr  = 5'd4;
         scan_start = (cycle_cnt == ign_at);
         #1;
         chk("scan_req0_ready", req0_ready, 0);
         chk("scan_req1_ready", req1_ready, 0);
         chk("scan_busy", scan_busy, busy_exp);
      end
      idle(1);
   endtask

   initial begin
      #3;
      chk_zero_outputs();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Contention: alternating 0,1,0,1 from the post-reset pointer.
      cyc(1, 2, 8'h03, 1, 9, 8'h0A, 0, 1, 0);
      cyc(1, 2, 8'h03, 1, 9, 8'h0A, 0, 0, 1);
      cyc(1, 2, 8'h03, 1, 9, 8'h0A, 0, 1, 0);
      cyc(1, 2, 8'h03, 1, 9, 8'h0A, 0, 0, 1);
      idle(6);

      // Single lookup on requester 0.
      cyc(1, 5, 8'h06, 0, 0, 0, 0, 1, 0);
      idle(6);

      // Plain scan; start beats simultaneous requester valids.
      cyc(1, 3, 0, 1, 4, 0, 1, 0, 0);
      s0 = cycle_cnt + 1;
      qs.push_back('{d: 8'h10, cyc: s0 + 34});
      scan_run(s0, 0);

      // Requester 1 granted one edge before the scan starts.
      cyc(0, 0, 0, 1, 31, 8'h20, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      s0 = cycle_cnt + 1;
      qs.push_back('{d: 8'h10, cyc: s0 + 34});
      scan_run(s0, 0);

      // Start pulse during SCAN is ignored.
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      s0 = cycle_cnt + 1;
      qs.push_back('{d: 8'h10, cyc: s0 + 34});
      scan_run(s0, s0 + 5);
      idle(6);

      // Reset with a lookup in flight: no response afterwards.
      cyc(1, 7, 0, 0, 0, 0, 0, 1, 0);
      q0.delete();
      idle(1);
      reset = 1'b1;
      #1;
      chk_zero_outputs();
      @(negedge clock);
      reset = 1'b0;
      idle(6);

      // Reset mid-scan: outputs clear at once and no scan_done follows.
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      s0 = cycle_cnt + 1;
      do begin
         @(negedge clock);
         scan_start = 1'b0;
      end while (cycle_cnt < s0 + 10);
      #1;
      reset = 1'b1;
      #1;
      chk_zero_outputs();
      @(negedge clock);
      reset = 1'b0;
      idle(40);

      // Lookup after reset still returns correct data.
      cyc(1, 12, 8'h0D, 0, 0, 0, 0, 1, 0);
      idle(8);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("qs_drained", qs.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
